// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: E-stage handshake and operand bus between the pipeline and the
// HI/LO multiply/divide controller.
//   start    : HILO-class instruction valid in E this cycle
//   op       : operation code (1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo)
//   kill     : exception/interrupt taken this cycle, blocks acceptance
//   a, b     : forwarded rs / rt operands
//   busy     : multiply/divide in flight
//   stall    : stall request to the hazard unit
//   hilo_out : HI for mfhi, LO for mflo, else zero
interface mdu_ctrl_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;

    logic              start;
    logic [OP_W-1:0]   op;
    logic              kill;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              busy;
    logic              stall;
    logic [DATA_W-1:0] hilo_out;

    modport master (
        output start, op, kill, a, b,
        input  busy, stall, hilo_out
    );

    modport slave (
        input  start, op, kill, a, b,
        output busy, stall, hilo_out
    );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle HI/LO unit controller (mult/multu, optional div/divu,
// mfhi/mflo/mthi/mtlo) with fixed busy latency and hazard stall request.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : asynchronous active-low reset
//   bus   : mdu_ctrl_if.slave (start, op, kill, a, b -> busy, stall, hilo_out)
// Configuration:
//   MDU_DIV_EN : when defined, div/divu are supported; otherwise ops 3/4 are
//                treated as no-ops and no divider is built.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic        clk,
    input logic        reset,
    mdu_ctrl_if.slave  bus
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam int unsigned DATA_W     = 32;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  hi_q, hi_d;
    logic [DATA_W-1:0]  lo_q, lo_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic               sgn_q, sgn_d;
    logic               busy_q, busy_d;

    logic               accept_c;
    logic               long_op_c;
    logic [63:0]        a_ext_c;
    logic [63:0]        b_ext_c;
    logic [63:0]        prod_c;

    // Acceptance only from IDLE and only when the instruction is not killed.
    assign accept_c = bus.start & ~bus.kill & (state_q == IDLE);

    // Ops that occupy the unit for multiple cycles.
`ifdef MDU_DIV_EN
    assign long_op_c = (bus.op == OP_MULT) | (bus.op == OP_MULTU) |
                       (bus.op == OP_DIV)  | (bus.op == OP_DIVU);
`else
    assign long_op_c = (bus.op == OP_MULT) | (bus.op == OP_MULTU);
`endif

    // Sign- or zero-extend latched operands; the low 64 bits of the product
    // are then correct for both signed and unsigned multiply.
    assign a_ext_c = {{DATA_W{sgn_q & a_q[DATA_W-1]}}, a_q};
    assign b_ext_c = {{DATA_W{sgn_q & b_q[DATA_W-1]}}, b_q};
    assign prod_c  = a_ext_c * b_ext_c;

`ifdef MDU_DIV_EN
    logic [DATA_W-1:0] quo_c;
    logic [DATA_W-1:0] rem_c;

    // Quotient/remainder from latched operands; SV division truncates toward
    // zero so the remainder carries the dividend's sign.
    always_comb begin
        quo_c = '0;
        rem_c = '0;
        if (b_q != '0) begin
            if (sgn_q) begin
                quo_c = DATA_W'($signed(a_q) / $signed(b_q));
                rem_c = DATA_W'($signed(a_q) % $signed(b_q));
            end else begin
                quo_c = a_q / b_q;
                rem_c = a_q % b_q;
            end
        end
    end
`endif

    // Next-state and register-update logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        busy_d  = busy_q;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            state_d = MUL;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            busy_d  = 1'b1;
                            a_d     = bus.a;
                            b_d     = bus.b;
                            sgn_d   = (bus.op == OP_MULT);
                        end
`ifdef MDU_DIV_EN
                        OP_DIV, OP_DIVU: begin
                            state_d = DIV;
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            busy_d  = 1'b1;
                            a_d     = bus.a;
                            b_d     = bus.b;
                            sgn_d   = (bus.op == OP_DIV);
                        end
`endif
                        OP_MTHI: hi_d = bus.a;
                        OP_MTLO: lo_d = bus.a;
                        default: ;
                    endcase
                end
            end

            MUL: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    hi_d    = prod_c[63:32];
                    lo_d    = prod_c[31:0];
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end
            end

            DIV: begin
`ifdef MDU_DIV_EN
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    // Divide by zero keeps full latency but leaves HI/LO alone.
                    if (b_q != '0) begin
                        hi_d = rem_c;
                        lo_d = quo_c;
                    end
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end
`else
                // Unreachable without a divider; recover to IDLE.
                state_d = IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
`endif
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and data registers; reset discards any pending result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.busy = busy_q;

    // Stall is combinational on start so the issuing instruction holds in E;
    // gated by reset so it is forced low while reset is asserted.
    assign bus.stall = reset & (busy_q | (bus.start & long_op_c));

    // Move-from read port, combinational from the current HI/LO.
    always_comb begin
        bus.hilo_out = '0;
        if (bus.op == OP_MFHI) begin
            bus.hilo_out = hi_q;
        end else if (bus.op == OP_MFLO) begin
            bus.hilo_out = lo_q;
        end
    end

endmodule
